// File: rtl/dg_ret_stack.sv
// dg_ret_stack: parametrised return-address stack for DG-series controller
// cores. entry[0] is the top of stack and drives top_addr directly. Tracks
// occupancy, offers a selectable overflow policy, sticky overflow/underflow
// flags and a push+pop replace-top operation.
module dg_ret_stack #(
   parameter int AW       = 10,
   parameter int DEPTH    = 4,
   parameter int OVF_MODE = 0,
   // Derived from DEPTH; leave at its default.
   parameter int CW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          push,
   input  logic          pop,
   input  logic          clr_err,
   input  logic [AW-1:0] push_addr,
   output logic [AW-1:0] top_addr,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          ovf,
   output logic          unf
);

   logic [AW-1:0] entry_q [DEPTH];
   logic [AW-1:0] entry_d [DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   logic          empty_w, full_w;
   logic          ovf_set, unf_set;

   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == CW'(DEPTH));

   // Next-state: select one operation per enabled cycle, then merge error
   // sets with clr_err so a set in the clearing cycle wins for that flag.
   always_comb begin
      entry_d = entry_q;
      count_d = count_q;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      ovf_d   = ovf_q;
      unf_d   = unf_q;

      if (ena) begin
         if (push && (!pop || empty_w)) begin
            // Push only, or push+pop on an empty stack (acts as a push).
            if (full_w) begin
               ovf_set = 1'b1;
               if (OVF_MODE == 0) begin
                  for (int unsigned i = DEPTH - 1; i > 0; i--) begin
                     entry_d[i] = entry_q[i-1];
                  end
                  entry_d[0] = push_addr;
               end
            end else begin
               for (int unsigned i = DEPTH - 1; i > 0; i--) begin
                  entry_d[i] = entry_q[i-1];
               end
               entry_d[0] = push_addr;
               count_d    = count_q + CW'(1);
            end
         end else if (push && pop) begin
            // Replace top on a non-empty stack.
            entry_d[0] = push_addr;
         end else if (pop) begin
            // Shift up; bottom entry keeps its value and is replicated.
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
               entry_d[i] = entry_q[i+1];
            end
            if (empty_w) begin
               unf_set = 1'b1;
            end else begin
               count_d = count_q - CW'(1);
            end
         end

         ovf_d = (ovf_q & ~clr_err) | ovf_set;
         unf_d = (unf_q & ~clr_err) | unf_set;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         entry_q <= entry_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign top_addr = entry_q[0];
   assign count    = count_q;
   assign empty    = empty_w;
   assign full     = full_w;
   assign ovf      = ovf_q;
   assign unf      = unf_q;

endmodule

// File: doc/dg_ret_stack.md
# dg_ret_stack

Parametrised hardware return-address stack for the DG-series 4-bit controller cores; successor to the fixed four-level, 10-bit call stack shift register. Generalised in address width and depth. Adds an occupancy counter, empty/full status, selectable overflow policy, sticky overflow/underflow error flags and a combined push+pop (replace-top) operation. Sits beside the program counter: CALL pushes the return PC, RET pops it onto `top_addr`.

## Interface

- `AW`, 10, address width in bits (≥1)
- `DEPTH`, 4, number of stack entries (≥2)
- `OVF_MODE`, 0, overflow policy: 0 = discard oldest (shift-register behaviour), 1 = reject push
- `CW`, `$clog2(DEPTH+1)`, width of `count` (derived, not overridden)

- `clk` in 1: single clock; all state changes on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `ena` in 1: operation enable; when 0 the block holds all state
- `push` in 1: push `push_addr` this cycle
- `pop` in 1: pop top entry this cycle
- `clr_err` in 1: clear sticky `ovf`/`unf`
- `push_addr` in AW: return address to push
- `top_addr` out AW: current entry 0, combinational from storage
- `count` out CW: valid entries, 0..DEPTH
- `empty` out 1: `count == 0`
- `full` out 1: `count == DEPTH`
- `ovf` out 1: sticky, push attempted while full
- `unf` out 1: sticky, pop attempted while empty

## Operation

- Storage is `entry[0..DEPTH-1]`, AW bits each. `entry[0]` is the top.
- Reset (async, `rst_n`=0):
  - all entries = 0, `count` = 0, `ovf` = `unf` = 0
  - `empty` = 1, `full` = 0, `top_addr` = 0
- `ena`=0: nothing changes, including `clr_err` handling.
- With `ena`=1, one operation is selected per cycle:
  - **Push only**, not full: `entry[i+1]<=entry[i]`; `entry[0]<=push_addr`; `count+1`.
  - **Push only**, full, `OVF_MODE`=0: shift as above; `entry[DEPTH-1]` is lost; `count` stays DEPTH; `ovf` is set.
  - **Push only**, full, `OVF_MODE`=1: storage and `count` are unchanged; `ovf` is set.
  - **Pop only**, not empty: `entry[i]<=entry[i+1]`; `entry[DEPTH-1]` is retained, so the bottom is replicated; `count-1`.
  - **Pop only**, empty: same shift as a normal pop; `count` stays 0; `unf` is set.
  - **Push+pop**, not empty: replace top. `entry[0]<=push_addr`, other entries unchanged, `count` unchanged, no flag set.
  - **Push+pop**, empty: treated as push only; `count`=1, `unf` is not set.
  - **Neither**: hold.
- Sticky flags:
  - `clr_err`=1 clears `ovf` and `unf`.
  - If an error condition occurs in the same cycle as `clr_err`, the set wins for that flag. The other flag still clears.
- Width rules:
  - `count` never wraps; it is saturated by the rules above.
  - `push_addr` is stored unmodified.
  - No arithmetic is performed on addresses.

## Timing

- Latency is 1 cycle. After the edge that samples a push, `top_addr` shows `push_addr`. After a pop edge, `top_addr` shows the previous `entry[1]`.
- `top_addr`, `empty` and `full` are combinational from registers. There is no input-to-output combinational path.
- `count`, `ovf` and `unf` are registered and update on the same edge as the storage.
- Back-to-back operations are supported every cycle with no bubbles.
- A reset assertion mid-operation forces reset values immediately, with no clock required. The first operation after deassertion is sampled on the first rising `clk` edge with `rst_n`=1.
- Inputs must be stable around the rising edge of `clk`. There are no other handshake rules; the block is always ready.

## Test plan

- **Reset, then push/pop sequence.** Reset, then push 0x011, 0x022, 0x033 -> `top_addr`=0x033, `count`=3. Pop ×3 -> `top_addr` 0x022, then 0x011, then the bottom-replicated value. `count`=0, `empty`=1, `ovf`=`unf`=0.
- **Overflow, `OVF_MODE`=0, DEPTH=4.** Push 1,2,3,4,5 -> `full`=1, `count`=4, `ovf`=1. Pop ×4 -> `top_addr` 4, 3, 2, 2 (value 1 lost, bottom replicated).
- **Overflow, `OVF_MODE`=1, DEPTH=4.** Push 1,2,3,4,5 -> `top_addr`=4, `count`=4, `ovf`=1. Pop ×4 -> 3, 2, 1, 1.
- **Underflow and `clr_err` priority.** On an empty stack, pop -> `unf`=1, `count`=0. Then `clr_err`+pop together -> `unf` stays 1. Then `clr_err` alone -> `unf`=0.
- **Replace top and `ena` gating.**
  - After push 0x100, 0x200: push+pop with 0x3FF -> `top_addr`=0x3FF, `count`=2.
  - On the empty stack, push+pop with 0x055 -> `count`=1, `unf`=0.
  - With `ena`=0 and push asserted -> no change to any output.
- **Async reset mid-operation.** With `count`=3, assert `rst_n`=0 between clock edges -> all outputs reach reset values before the next edge. Deassert, then push 0x2AA -> `count`=1, `top_addr`=0x2AA.
